dac_cfg_sequencer: RTL and testbench

- Owns every DAC and PLL configuration change.
- Takes MCU format controls (sample rate, 44/48 family, DSD/PCM, mute, reset) and the MCLK select, and synchronizes and debounces them.
- On any change it runs a click-free sequence: mute, hold DAC and NOS datapath in reset, reprogram PLL, wait for lock, release reset, unmute.
- Sits between MCU/jumper inputs and the DAC pins, PLL select pins and `nos_dac_transceiver` reset.

---
 rtl/dac_cfg_sequencer_pkg.sv | 53 +++++
 rtl/dac_cfg_sequencer_cfg_sync_debounce.sv | 68 ++++++
 rtl/dac_cfg_sequencer.sv | 141 ++++++++++++++
 tb/tb_dac_cfg_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_cfg_sequencer_pkg.sv
// Shared types for the DAC/PLL configuration sequencer.
// Clock, rate and sequencer encodings plus the PLL select mapping.
package dac_cfg_sequencer_pkg;

    typedef enum logic [1:0] {
        BITRATE_X1 = 2'd0,
        BITRATE_X2 = 2'd1,
        BITRATE_X4 = 2'd2,
        BITRATE_X8 = 2'd3
    } BITRATE;

    typedef enum logic [2:0] {
        MCLK_128fs  = 3'd0,
        MCLK_256fs  = 3'd1,
        MCLK_384fs  = 3'd2,
        MCLK_512fs  = 3'd3,
        MCLK_768fs  = 3'd4,
        MCLK_1024fs = 3'd5,
        MCLK_1152fs = 3'd6,
        MCLK_1536fs = 3'd7
    } MCLK;

    typedef enum logic [1:0] {
        BITNUM_16 = 2'd0,
        BITNUM_24 = 2'd1,
        BITNUM_32 = 2'd2,
        BITNUM_1  = 2'd3
    } BITNUM;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        RUN      = 3'd1,
        MUTE     = 3'd2,
        RST_HOLD = 3'd3,
        PLL_WAIT = 3'd4,
        RELEASE  = 3'd5
    } SEQ_STATE;

    typedef struct packed {
        logic [1:0] f;
        logic       fam;
        logic       dsd_on;
        logic [2:0] mclk;
    } DAC_CFG;

    // Upper bit picks the 44.1k/48k family, lower bit the x3 (384/768fs) ratio.
    function automatic logic [1:0] pll_sel(input DAC_CFG c);
        logic x3;
        x3 = (c.mclk == MCLK_384fs) || (c.mclk == MCLK_768fs);
        return {c.fam, x3};
    endfunction

endpackage

// File: rtl/dac_cfg_sequencer_cfg_sync_debounce.sv
// Synchronizes MCU/jumper controls and debounces the format config.
// Reports the last config that stayed unchanged long enough.
module cfg_sync_debounce
    import dac_cfg_sequencer_pkg::*;
#(
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mcu_f,
    input  logic       mcu_44_48,
    input  logic       mcu_dsd_on,
    input  logic [2:0] mclk_sel,
    input  logic       mcu_mute,
    input  logic       mcu_dac_reset,
    output logic       cfg_stable,
    output DAC_CFG     stable_cfg,
    output logic       mute_sync,
    output logic       dac_reset_sync
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES - 1);

    DAC_CFG           cfg_in;
    DAC_CFG           cfg_meta;
    DAC_CFG           cfg_sync;
    DAC_CFG           cfg_prev;
    DAC_CFG           cfg_held;
    logic [1:0]       ctl_meta;
    logic [1:0]       ctl_sync;
    logic [CNT_W-1:0] stable_cnt;

    assign cfg_in = {mcu_f, mcu_44_48, mcu_dsd_on, mclk_sel};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_meta   <= '0;
            cfg_sync   <= '0;
            cfg_prev   <= '0;
            cfg_held   <= '0;
            ctl_meta   <= '0;
            ctl_sync   <= '0;
            stable_cnt <= '0;
        end else begin
            cfg_meta <= cfg_in;
            cfg_sync <= cfg_meta;
            ctl_meta <= {mcu_mute, mcu_dac_reset};
            ctl_sync <= ctl_meta;
            cfg_prev <= cfg_sync;
            if (cfg_sync != cfg_prev) begin
                stable_cnt <= '0;
            end else if (stable_cnt < STABLE_MAX) begin
                stable_cnt <= stable_cnt + 1'b1;
            end
            if (cfg_stable) begin
                cfg_held <= cfg_prev;
            end
        end
    end

    // cfg_prev is the value being counted, so a fresh glitch never looks stable.
    assign cfg_stable     = (stable_cnt >= STABLE_MAX);
    assign stable_cfg     = cfg_stable ? cfg_prev : cfg_held;
    assign mute_sync      = ctl_sync[1];
    assign dac_reset_sync = ctl_sync[0];

endmodule

// File: rtl/dac_cfg_sequencer.sv
// Click-free DAC/PLL reconfiguration sequencer.
// Mutes, holds reset, reprograms the PLL, waits for lock, then releases.
module dac_cfg_sequencer
    import dac_cfg_sequencer_pkg::*;
#(
    parameter int STABLE_CYCLES   = 1024,
    parameter int MUTE_CYCLES     = 4096,
    parameter int RESET_CYCLES    = 256,
    parameter int PLL_LOCK_CYCLES = 65536,
    parameter int CNT_W           = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mcu_f,
    input  logic       mcu_44_48,
    input  logic       mcu_dsd_on,
    input  logic [2:0] mclk_sel,
    input  logic       mcu_mute,
    input  logic       mcu_dac_reset,
    output logic       dac_mute,
    output logic       dac_reset,
    output logic [1:0] dac_f,
    output logic       dac_44_48,
    output logic       dac_dsd,
    output logic [1:0] pll_s,
    output logic       datapath_rst,
    output logic       busy
);

    localparam logic [CNT_W-1:0] MUTE_LD  = CNT_W'(MUTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] PLL_LD   = CNT_W'(PLL_LOCK_CYCLES - 1);

    SEQ_STATE         state;
    DAC_CFG           cfg_app;
    logic [CNT_W-1:0] tmr;
    logic             cfg_stable;
    DAC_CFG           stable_cfg;
    logic             mute_sync;
    logic             dac_reset_sync;
    logic             tmr_done;
    logic             cfg_changed;

    cfg_sync_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .mcu_f          (mcu_f),
        .mcu_44_48      (mcu_44_48),
        .mcu_dsd_on     (mcu_dsd_on),
        .mclk_sel       (mclk_sel),
        .mcu_mute       (mcu_mute),
        .mcu_dac_reset  (mcu_dac_reset),
        .cfg_stable     (cfg_stable),
        .stable_cfg     (stable_cfg),
        .mute_sync      (mute_sync),
        .dac_reset_sync (dac_reset_sync)
    );

    assign tmr_done    = (tmr == '0);
    assign cfg_changed = cfg_stable && (stable_cfg != cfg_app);

    // Outputs are registered from the next state, so they change with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= INIT;
            dac_mute     <= 1'b1;
            dac_reset    <= 1'b1;
            datapath_rst <= 1'b1;
            busy         <= 1'b1;
            cfg_app      <= '0;
            pll_s        <= '0;
            tmr          <= '0;
        end else begin
            if (!tmr_done) begin
                tmr <= tmr - 1'b1;
            end
            unique case (state)
                INIT: begin
                    if (cfg_stable) begin
                        state   <= RST_HOLD;
                        tmr     <= RESET_LD;
                        cfg_app <= stable_cfg;
                        pll_s   <= pll_sel(stable_cfg);
                    end
                end
                RUN: begin
                    dac_mute <= mute_sync;
                    if (cfg_changed || dac_reset_sync) begin
                        state    <= MUTE;
                        tmr      <= MUTE_LD;
                        dac_mute <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                MUTE: begin
                    if (tmr_done) begin
                        state        <= RST_HOLD;
                        tmr          <= RESET_LD;
                        cfg_app      <= stable_cfg;
                        pll_s        <= pll_sel(stable_cfg);
                        dac_reset    <= 1'b1;
                        datapath_rst <= 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (tmr_done) begin
                        state <= PLL_WAIT;
                        tmr   <= PLL_LD;
                    end
                end
                PLL_WAIT: begin
                    // An MCU reset request parks the sequence here.
                    if (tmr_done && !dac_reset_sync) begin
                        state        <= RELEASE;
                        tmr          <= MUTE_LD;
                        dac_reset    <= 1'b0;
                        datapath_rst <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (tmr_done) begin
                        state    <= RUN;
                        dac_mute <= mute_sync;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign dac_f     = cfg_app.f;
    assign dac_44_48 = cfg_app.fam;
    assign dac_dsd   = ~cfg_app.dsd_on;

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// Directed self-checking bench for dac_cfg_sequencer.
// Small timing params keep every sequence short.
module tb_dac_cfg_sequencer;
    import dac_cfg_sequencer_pkg::*;

    localparam int P_MUTE = 0;
    localparam int P_RST  = 1;
    localparam int P_BUSY = 2;
    localparam int P_PLL  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mcu_f;
    logic       mcu_44_48;
    logic       mcu_dsd_on;
    logic [2:0] mclk_sel;
    logic       mcu_mute;
    logic       mcu_dac_reset;
    logic       dac_mute;
    logic       dac_reset;
    logic [1:0] dac_f;
    logic       dac_44_48;
    logic       dac_dsd;
    logic [1:0] pll_s;
    logic       datapath_rst;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int n;
    logic seen;

    dac_cfg_sequencer #(
        .STABLE_CYCLES   (4),
        .MUTE_CYCLES     (8),
        .RESET_CYCLES    (2),
        .PLL_LOCK_CYCLES (16),
        .CNT_W           (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mcu_f         (mcu_f),
        .mcu_44_48     (mcu_44_48),
        .mcu_dsd_on    (mcu_dsd_on),
        .mclk_sel      (mclk_sel),
        .mcu_mute      (mcu_mute),
        .mcu_dac_reset (mcu_dac_reset),
        .dac_mute      (dac_mute),
        .dac_reset     (dac_reset),
        .dac_f         (dac_f),
        .dac_44_48     (dac_44_48),
        .dac_dsd       (dac_dsd),
        .pll_s         (pll_s),
        .datapath_rst  (datapath_rst),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            P_MUTE:  return dac_mute;
            P_RST:   return dac_reset;
            P_BUSY:  return busy;
            default: return |pll_s;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val,
                            input int limit, output int cnt);
        cnt = 0;
        while (probe(sel) !== val && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mute"}, int'(dac_mute), 1);
        chk({tag, "_dacrst"}, int'(dac_reset), 1);
        chk({tag, "_dprst"}, int'(datapath_rst), 1);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_f"}, int'(dac_f), 0);
        chk({tag, "_pll"}, int'(pll_s), 0);
        chk({tag, "_dsd"}, int'(dac_dsd), 1);
    endtask

    initial begin
        reset         = 1'b1;
        mcu_f         = 2'b01;
        mcu_44_48     = 1'b1;
        mcu_dsd_on    = 1'b0;
        mclk_sel      = MCLK_384fs;
        mcu_mute      = 1'b0;
        mcu_dac_reset = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");

        // Power-up sequence: 2 sync + 4 stable + 1 -> RST_HOLD.
        reset = 1'b0;
        wait_for(P_PLL, 1'b1, 50, n);
        chk("init_to_rsthold", n, 7);
        chk("init_f", int'(dac_f), 1);
        chk("init_pll", int'(pll_s), 3);
        chk("init_hold_rst", int'(dac_reset), 1);
        wait_for(P_RST, 1'b0, 50, n);
        chk("init_rst_fall", n, 18);
        chk("init_dprst", int'(datapath_rst), 0);
        chk("init_rel_mute", int'(dac_mute), 1);
        wait_for(P_MUTE, 1'b0, 50, n);
        chk("init_mute_fall", n, 8);
        chk("init_busy", int'(busy), 0);

        // Rate change 01 -> 10.
        mcu_f = 2'b10;
        wait_for(P_MUTE, 1'b1, 20, n);
        chk("rate_mute_lat", n, 7);
        chk("rate_busy", int'(busy), 1);
        chk("rate_mute_norst", int'(dac_reset), 0);
        wait_for(P_RST, 1'b1, 20, n);
        chk("rate_rst_lat", n, 8);
        chk("rate_f", int'(dac_f), 2);
        chk("rate_pll", int'(pll_s), 3);
        wait_for(P_BUSY, 1'b0, 60, n);
        chk("rate_run_lat", n, 26);
        chk("rate_unmute", int'(dac_mute), 0);

        // Two-cycle glitch must not start a sequence.
        mcu_f = 2'b11;
        tick();
        tick();
        mcu_f = 2'b10;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("glitch_busy", int'(seen), 0);
        chk("glitch_f", int'(dac_f), 2);

        // Mute follows in RUN with 3-cycle latency.
        mcu_mute = 1'b1;
        wait_for(P_MUTE, 1'b1, 10, n);
        chk("mute_on_lat", n, 3);
        chk("mute_busy", int'(busy), 0);
        mcu_mute = 1'b0;
        wait_for(P_MUTE, 1'b0, 10, n);
        chk("mute_off_lat", n, 3);

        // Long MCU reset parks PLL_WAIT.
        mcu_dac_reset = 1'b1;
        repeat (100) tick();
        chk("hold_dacrst", int'(dac_reset), 1);
        chk("hold_dprst", int'(datapath_rst), 1);
        chk("hold_mute", int'(dac_mute), 1);
        chk("hold_busy", int'(busy), 1);
        mcu_dac_reset = 1'b0;
        wait_for(P_RST, 1'b0, 10, n);
        chk("hold_release_lat", n, 3);

        // Mute request during RELEASE is ignored.
        mcu_mute = 1'b1;
        repeat (3) tick();
        chk("rel_mute_forced", int'(dac_mute), 1);
        mcu_mute = 1'b0;
        wait_for(P_BUSY, 1'b0, 20, n);
        chk("rel_remaining", n, 5);
        chk("rel_unmute", int'(dac_mute), 0);
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("rel_no_reseq", int'(seen), 0);

        // Config change plus MCU reset together: one sequence.
        mcu_f         = 2'b00;
        mcu_dac_reset = 1'b1;
        wait_for(P_MUTE, 1'b1, 10, n);
        chk("both_mute_lat", n, 3);
        mcu_dac_reset = 1'b0;
        wait_for(P_RST, 1'b1, 20, n);
        chk("both_rst_lat", n, 8);
        chk("both_f", int'(dac_f), 0);
        wait_for(P_BUSY, 1'b0, 60, n);
        chk("both_run_lat", n, 26);
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("both_single", int'(seen), 0);

        // DSD on flips dac_dsd low.
        mcu_dsd_on = 1'b1;
        wait_for(P_RST, 1'b1, 30, n);
        chk("dsd_rst_lat", n, 15);
        chk("dsd_pin", int'(dac_dsd), 0);
        wait_for(P_BUSY, 1'b0, 60, n);
        chk("dsd_run_lat", n, 26);

        // 44.1k family, 768fs, then reset during PLL_WAIT.
        mcu_44_48 = 1'b0;
        mclk_sel  = MCLK_768fs;
        wait_for(P_RST, 1'b1, 30, n);
        chk("fam_rst_lat", n, 15);
        chk("fam_pll", int'(pll_s), 1);
        chk("fam_pin", int'(dac_44_48), 0);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        tick();
        reset = 1'b0;
        wait_for(P_BUSY, 1'b0, 100, n);
        chk("recover_lat", n, 33);
        chk("recover_pll", int'(pll_s), 1);
        chk("recover_f", int'(dac_f), 0);
        chk("recover_dsd", int'(dac_dsd), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
